mem_access: RTL and testbench

- MEM-stage data-memory access unit. It sits between the EX/MEM pipeline register and the MEM/WB pipeline register.
- Consumes the EX/MEM outputs and drives a req/ack data-memory bus.
- Raises a stall request to the pipeline controller while an access is outstanding.
- Hands the final writeback triple (address, enable, data) to MEM/WB.

---
 rtl/mem_access.sv | 212 +++++++++++++++++++++
 tb/tb_mem_access.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// MEM-stage data-memory access unit: issues req/ack bus accesses,
// stalls the pipeline while busy and hands the writeback triple to MEM/WB.
module mem_access #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  mem_waddr,
    input  logic        mem_we,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_op,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_sdata,
    input  logic [5:0]  ctrl_stall,
    input  logic [31:0] dm_rdata,
    input  logic        dm_ack,
    output logic        dm_req,
    output logic        dm_wr,
    output logic [31:0] dm_addr,
    output logic [3:0]  dm_be,
    output logic [31:0] dm_wdata,
    output logic        stall_req,
    output logic [4:0]  wb_waddr,
    output logic        wb_we,
    output logic [31:0] wb_wdata,
    output logic        err_misalign,
    output logic        err_timeout
);

    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LBU = 4'd2;
    localparam logic [3:0] OP_LH  = 4'd3;
    localparam logic [3:0] OP_LHU = 4'd4;
    localparam logic [3:0] OP_LW  = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;
    localparam logic [7:0] CNT_MAX = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t      state;
    state_t      state_nx;
    logic [7:0]  cnt;
    logic [31:0] rdata_q;
    logic        err_q;
    logic [3:0]  op_q;
    logic [1:0]  off_q;

    logic        is_mem;
    logic        is_store;
    logic        misal;
    logic        issue;
    logic        timeout_hit;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;
    logic [31:0] shifted;
    logic [31:0] load_data;
    logic        load_q;

    logic unused_stall_bits;
    assign unused_stall_bits = ^{ctrl_stall[5], ctrl_stall[3:0]};

    always_comb begin
        is_mem     = 1'b0;
        is_store   = 1'b0;
        misal      = 1'b0;
        lane_be    = 4'b0000;
        lane_wdata = mem_sdata;
        case (mem_op)
            OP_LB, OP_LBU: is_mem = 1'b1;
            OP_LH, OP_LHU: begin
                is_mem = 1'b1;
                misal  = mem_addr[0];
            end
            OP_LW: begin
                is_mem = 1'b1;
                misal  = |mem_addr[1:0];
            end
            OP_SB: begin
                is_mem     = 1'b1;
                is_store   = 1'b1;
                lane_be    = 4'b0001 << mem_addr[1:0];
                lane_wdata = {4{mem_sdata[7:0]}};
            end
            OP_SH: begin
                is_mem     = 1'b1;
                is_store   = 1'b1;
                misal      = mem_addr[0];
                lane_be    = 4'b0011 << mem_addr[1:0];
                lane_wdata = {2{mem_sdata[15:0]}};
            end
            OP_SW: begin
                is_mem     = 1'b1;
                is_store   = 1'b1;
                misal      = |mem_addr[1:0];
                lane_be    = 4'b1111;
            end
            default: is_mem = 1'b0;
        endcase
    end

    assign issue       = (state == S_IDLE) && is_mem && !misal;
    assign timeout_hit = (state == S_BUSY) && !dm_ack && (cnt == CNT_MAX);

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: if (issue) state_nx = S_BUSY;
            S_BUSY: if (dm_ack || timeout_hit) state_nx = S_DONE;
            S_DONE: if (!ctrl_stall[4]) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Bus signals are launched once at issue and only dm_req changes afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            dm_req      <= 1'b0;
            dm_wr       <= 1'b0;
            dm_addr     <= '0;
            dm_be       <= '0;
            dm_wdata    <= '0;
            rdata_q     <= '0;
            cnt         <= '0;
            err_timeout <= 1'b0;
            err_q       <= 1'b0;
            op_q        <= '0;
            off_q       <= '0;
        end else begin
            err_timeout <= 1'b0;
            if (issue) begin
                dm_req   <= 1'b1;
                dm_wr    <= is_store;
                dm_addr  <= {mem_addr[31:2], 2'b00};
                dm_be    <= is_store ? lane_be : 4'b1111;
                dm_wdata <= lane_wdata;
                cnt      <= '0;
                err_q    <= 1'b0;
                op_q     <= mem_op;
                off_q    <= mem_addr[1:0];
            end else if (state == S_BUSY) begin
                if (dm_ack) begin
                    rdata_q <= dm_rdata;
                    dm_req  <= 1'b0;
                end else if (timeout_hit) begin
                    dm_req      <= 1'b0;
                    err_timeout <= 1'b1;
                    rdata_q     <= '0;
                    err_q       <= 1'b1;
                end else begin
                    cnt <= cnt + 8'd1;
                end
            end
        end
    end

    assign shifted = rdata_q >> {off_q, 3'b000};
    assign load_q  = (op_q >= OP_LB) && (op_q <= OP_LW);

    always_comb begin
        case (op_q)
            OP_LB:   load_data = {{24{shifted[7]}}, shifted[7:0]};
            OP_LBU:  load_data = {24'd0, shifted[7:0]};
            OP_LH:   load_data = {{16{shifted[15]}}, shifted[15:0]};
            OP_LHU:  load_data = {16'd0, shifted[15:0]};
            default: load_data = rdata_q;
        endcase
    end

    always_comb begin
        stall_req    = 1'b0;
        wb_waddr     = mem_waddr;
        wb_we        = mem_we;
        wb_wdata     = mem_wdata;
        err_misalign = 1'b0;
        if (rst) begin
            wb_waddr = '0;
            wb_we    = 1'b0;
            wb_wdata = '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (is_mem) begin
                        wb_we        = 1'b0;
                        err_misalign = misal;
                        stall_req    = !misal;
                    end
                end
                S_BUSY: begin
                    stall_req = 1'b1;
                    wb_we     = 1'b0;
                end
                S_DONE: begin
                    if (load_q) begin
                        wb_we    = mem_we & ~err_q;
                        wb_wdata = load_data;
                    end else begin
                        wb_we = 1'b0;
                    end
                end
                default: wb_we = 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: loads, stores, misalignment,
// timeout, MEM/WB hold in DONE and reset during BUSY.
module tb_mem_access;

    logic        clk;
    logic        rst;
    logic [4:0]  mem_waddr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_op;
    logic [31:0] mem_addr;
    logic [31:0] mem_sdata;
    logic [5:0]  ctrl_stall;
    logic [31:0] dm_rdata;
    logic        dm_ack;
    logic        dm_req;
    logic        dm_wr;
    logic [31:0] dm_addr;
    logic [3:0]  dm_be;
    logic [31:0] dm_wdata;
    logic        stall_req;
    logic [4:0]  wb_waddr;
    logic        wb_we;
    logic [31:0] wb_wdata;
    logic        err_misalign;
    logic        err_timeout;

    int n_chk = 0;
    int n_bad = 0;

    mem_access #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .mem_waddr(mem_waddr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_op(mem_op), .mem_addr(mem_addr), .mem_sdata(mem_sdata),
        .ctrl_stall(ctrl_stall), .dm_rdata(dm_rdata), .dm_ack(dm_ack),
        .dm_req(dm_req), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_be(dm_be),
        .dm_wdata(dm_wdata), .stall_req(stall_req), .wb_waddr(wb_waddr),
        .wb_we(wb_we), .wb_wdata(wb_wdata),
        .err_misalign(err_misalign), .err_timeout(err_timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h want=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_access(input logic [3:0] op, input logic [31:0] addr,
                               input logic [31:0] rd, input logic [31:0] exp,
                               input string tag);
        mem_op = op; mem_addr = addr; mem_we = 1'b1;
        mem_waddr = 5'd7; mem_wdata = 32'h0000_1234;
        @(negedge clk);
        chk({tag, "_idle_stall"}, stall_req, 1);
        chk({tag, "_idle_we"}, wb_we, 0);
        tick();
        dm_ack = 1'b1; dm_rdata = rd;
        @(negedge clk);
        chk({tag, "_busy_req"}, dm_req, 1);
        chk({tag, "_busy_stall"}, stall_req, 1);
        chk({tag, "_addr"}, dm_addr, {addr[31:2], 2'b00});
        chk({tag, "_be"}, dm_be, 4'b1111);
        chk({tag, "_wr"}, dm_wr, 0);
        tick();
        dm_ack = 1'b0; dm_rdata = 32'h0;
        @(negedge clk);
        chk({tag, "_done_stall"}, stall_req, 0);
        chk({tag, "_done_req"}, dm_req, 0);
        chk({tag, "_done_we"}, wb_we, 1);
        chk({tag, "_done_data"}, wb_wdata, exp);
        tick();
        mem_op = 4'd0;
    endtask

    task automatic store_access(input logic [3:0] op, input logic [31:0] addr,
                                input logic [31:0] sd, input logic [3:0] be,
                                input logic [31:0] wd, input string tag);
        mem_op = op; mem_addr = addr; mem_sdata = sd; mem_we = 1'b1;
        @(negedge clk);
        chk({tag, "_idle_stall"}, stall_req, 1);
        tick();
        dm_ack = 1'b1;
        @(negedge clk);
        chk({tag, "_req"}, dm_req, 1);
        chk({tag, "_wr"}, dm_wr, 1);
        chk({tag, "_be"}, dm_be, be);
        chk({tag, "_wdata"}, dm_wdata, wd);
        chk({tag, "_busy_we"}, wb_we, 0);
        tick();
        dm_ack = 1'b0;
        @(negedge clk);
        chk({tag, "_done_stall"}, stall_req, 0);
        chk({tag, "_done_we"}, wb_we, 0);
        tick();
        mem_op = 4'd0;
    endtask

    initial begin
        rst = 1'b1; mem_waddr = '0; mem_we = 1'b0; mem_wdata = '0;
        mem_op = '0; mem_addr = '0; mem_sdata = '0; ctrl_stall = '0;
        dm_rdata = '0; dm_ack = 1'b0;
        tick(); tick();
        @(negedge clk);
        chk("rst_req", dm_req, 0);
        chk("rst_stall", stall_req, 0);
        chk("rst_we", wb_we, 0);
        chk("rst_tmo", err_timeout, 0);
        chk("rst_be", dm_be, 0);
        tick();
        rst = 1'b0;

        load_access(4'd5, 32'h100, 32'hDEADBEEF, 32'hDEADBEEF, "lw");
        load_access(4'd1, 32'h103, 32'h80112233, 32'hFFFFFF80, "lb");
        load_access(4'd2, 32'h103, 32'h80112233, 32'h00000080, "lbu");
        load_access(4'd3, 32'h102, 32'h80112233, 32'hFFFF8011, "lh");
        load_access(4'd4, 32'h100, 32'h80112233, 32'h00002233, "lhu");

        store_access(4'd6, 32'h101, 32'h000000AB, 4'b0010, 32'hABABABAB, "sb");
        store_access(4'd7, 32'h102, 32'h0000CAFE, 4'b1100, 32'hCAFECAFE, "sh");
        store_access(4'd8, 32'h104, 32'h01234567, 4'b1111, 32'h01234567, "sw");

        // misaligned word load, then a plain ALU op
        mem_op = 4'd5; mem_addr = 32'h102; mem_we = 1'b1;
        mem_waddr = 5'd9; mem_wdata = 32'h0000_55AA;
        @(negedge clk);
        chk("mis_stall", stall_req, 0);
        chk("mis_err", err_misalign, 1);
        chk("mis_we", wb_we, 0);
        chk("mis_wdata", wb_wdata, 32'h0000_55AA);
        tick();
        mem_op = 4'd0;
        @(negedge clk);
        chk("mis_noreq", dm_req, 0);
        chk("none_we", wb_we, 1);
        chk("none_waddr", wb_waddr, 5'd9);
        chk("none_wdata", wb_wdata, 32'h0000_55AA);
        chk("none_err", err_misalign, 0);
        mem_op = 4'd12;
        @(negedge clk);
        chk("op12_stall", stall_req, 0);
        tick();
        mem_op = 4'd0;

        // timeout: four BUSY cycles without ack
        mem_op = 4'd5; mem_addr = 32'h200; mem_we = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("tmo_req", dm_req, 1);
            chk("tmo_nopulse", err_timeout, 0);
            tick();
        end
        @(negedge clk);
        chk("tmo_drop", dm_req, 0);
        chk("tmo_pulse", err_timeout, 1);
        chk("tmo_we", wb_we, 0);
        chk("tmo_stall", stall_req, 0);
        tick();
        mem_op = 4'd0;
        @(negedge clk);
        chk("tmo_pulse_end", err_timeout, 0);

        // MEM/WB hold while in DONE
        mem_op = 4'd5; mem_addr = 32'h300; mem_we = 1'b1;
        tick();
        dm_ack = 1'b1; dm_rdata = 32'hA5A5_0F0F;
        tick();
        dm_ack = 1'b0; ctrl_stall = 6'b010000;
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clk);
            chk("hold_req", dm_req, 0);
            chk("hold_we", wb_we, 1);
            chk("hold_data", wb_wdata, 32'hA5A5_0F0F);
        end
        ctrl_stall = 6'b000000;
        tick();
        mem_op = 4'd0;
        @(negedge clk);
        chk("hold_exit_req", dm_req, 0);

        // reset during BUSY
        mem_op = 4'd5; mem_addr = 32'h400; mem_we = 1'b1;
        tick();
        @(negedge clk);
        chk("rb_req", dm_req, 1);
        rst = 1'b1;
        #1;
        chk("rb_stall_rst", stall_req, 0);
        tick();
        rst = 1'b0; mem_op = 4'd0;
        @(negedge clk);
        chk("rb_req_drop", dm_req, 0);
        chk("rb_stall", stall_req, 0);
        chk("rb_we", wb_we, 1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
